// File: rtl/bram_port_arbiter.sv
// Two-master round-robin arbiter in front of a simple-dual-port BRAM.
// Write port A and read port B are arbitrated independently; read responses are routed to their issuer.
module bram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_valid,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_ready,
  output logic                  m1_ready,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  bram_we_a,
  output logic [ADDR_WIDTH-1:0] bram_addr_a,
  output logic [DATA_WIDTH-1:0] bram_din_a,
  output logic                  bram_en_b,
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  input  logic [DATA_WIDTH-1:0] bram_dout_b
);

  logic wr_ptr;
  logic rd_ptr;
  logic rsp_valid;
  logic rsp_owner;

  logic m0_wr_req, m1_wr_req, m0_rd_req, m1_rd_req;
  logic wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
  logic wr_any, rd_any;

  // Request classification; reset masks every request so no grant can leak out.
  assign m0_wr_req = m0_valid &  m0_we & ~rst;
  assign m1_wr_req = m1_valid &  m1_we & ~rst;
  assign m0_rd_req = m0_valid & ~m0_we & ~rst;
  assign m1_rd_req = m1_valid & ~m1_we & ~rst;

  // Round-robin: a lone requester wins, on contention the pointed-to master wins.
  assign wr_gnt0 = m0_wr_req & (~m1_wr_req | ~wr_ptr);
  assign wr_gnt1 = m1_wr_req & (~m0_wr_req |  wr_ptr);
  assign rd_gnt0 = m0_rd_req & (~m1_rd_req | ~rd_ptr);
  assign rd_gnt1 = m1_rd_req & (~m0_rd_req |  rd_ptr);

  assign wr_any = wr_gnt0 | wr_gnt1;
  assign rd_any = rd_gnt0 | rd_gnt1;

  assign m0_ready = wr_gnt0 | rd_gnt0;
  assign m1_ready = wr_gnt1 | rd_gnt1;

  // BRAM port A: winner's write, zeroed when idle.
  always_comb begin
    bram_we_a   = 1'b0;
    bram_addr_a = '0;
    bram_din_a  = '0;
    if (wr_gnt0) begin
      bram_we_a   = 1'b1;
      bram_addr_a = m0_addr;
      bram_din_a  = m0_wdata;
    end else if (wr_gnt1) begin
      bram_we_a   = 1'b1;
      bram_addr_a = m1_addr;
      bram_din_a  = m1_wdata;
    end
  end

  // BRAM port B: enable only on a grant so the output register otherwise holds.
  always_comb begin
    bram_en_b   = 1'b0;
    bram_addr_b = '0;
    if (rd_gnt0) begin
      bram_en_b   = 1'b1;
      bram_addr_b = m0_addr;
    end else if (rd_gnt1) begin
      bram_en_b   = 1'b1;
      bram_addr_b = m1_addr;
    end
  end

  // Pointers hand priority to the other master after each grant on their port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_any) wr_ptr <= wr_gnt0;
      if (rd_any) rd_ptr <= rd_gnt0;
    end
  end

  // Response tracker mirrors the one-cycle BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
    end else begin
      rsp_valid <= rd_any;
      rsp_owner <= rd_gnt1;
    end
  end

  // Masked by rst so a read granted just before reset never reports.
  assign m0_rvalid = rsp_valid & ~rsp_owner & ~rst;
  assign m1_rvalid = rsp_valid &  rsp_owner & ~rst;
  assign m_rdata   = bram_dout_b;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter with a behavioural BRAM and a read-response scoreboard.
module tb_bram_port_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_valid, m0_we, m1_valid, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m_rdata;
  logic          bram_we_a, bram_en_b;
  logic [AW-1:0] bram_addr_a, bram_addr_b;
  logic [DW-1:0] bram_din_a, bram_dout_b;

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_ready(m0_ready), .m1_ready(m1_ready),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m_rdata(m_rdata),
    .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a), .bram_din_a(bram_din_a),
    .bram_en_b(bram_en_b), .bram_addr_b(bram_addr_b), .bram_dout_b(bram_dout_b)
  );

  always #5 clk = ~clk;

  // Behavioural simple-dual-port BRAM: read-before-write on a same-address collision.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (bram_en_b) bram_dout_b <= mem[bram_addr_b];
    if (bram_we_a) mem[bram_addr_a] <= bram_din_a;
  end

  typedef struct packed {
    logic          master;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb [$];
  logic [DW-1:0] shadow [1 << AW];
  logic          mdl_wr_ptr = 1'b0;
  logic          mdl_rd_ptr = 1'b0;
  int            errors = 0;
  int            checks = 0;
  logic          obs_r0, obs_r1, obs_v0, obs_v1;
  logic [DW-1:0] obs_data;

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic step();
    logic          w0, w1, r0, r1, e_w0, e_w1, e_r0, e_r1, e_v0, e_v1;
    logic [AW-1:0] e_aa, e_ab;
    logic [DW-1:0] e_din, e_data;
    rsp_t          e;
    @(negedge clk);
    w0 = m0_valid &  m0_we & ~rst;
    w1 = m1_valid &  m1_we & ~rst;
    r0 = m0_valid & ~m0_we & ~rst;
    r1 = m1_valid & ~m1_we & ~rst;
    e_w0 = w0 & (!w1 || mdl_wr_ptr == 1'b0);
    e_w1 = w1 & (!w0 || mdl_wr_ptr == 1'b1);
    e_r0 = r0 & (!r1 || mdl_rd_ptr == 1'b0);
    e_r1 = r1 & (!r0 || mdl_rd_ptr == 1'b1);
    e_aa  = e_w0 ? m0_addr  : (e_w1 ? m1_addr  : '0);
    e_din = e_w0 ? m0_wdata : (e_w1 ? m1_wdata : '0);
    e_ab  = e_r0 ? m0_addr  : (e_r1 ? m1_addr  : '0);
    e_v0 = 1'b0; e_v1 = 1'b0; e_data = '0;
    if (rst) sb.delete();
    else if (sb.size() > 0) begin
      e = sb.pop_front();
      e_v0 = (e.master == 1'b0);
      e_v1 = (e.master == 1'b1);
      e_data = e.data;
    end
    obs_r0 = m0_ready; obs_r1 = m1_ready;
    obs_v0 = m0_rvalid; obs_v1 = m1_rvalid; obs_data = m_rdata;
    checks++; if (m0_ready !== (e_w0 | e_r0)) begin errors++; $display("FAIL m0_ready t=%0t got=%b exp=%b", $time, m0_ready, e_w0 | e_r0); end
    checks++; if (m1_ready !== (e_w1 | e_r1)) begin errors++; $display("FAIL m1_ready t=%0t got=%b exp=%b", $time, m1_ready, e_w1 | e_r1); end
    checks++; if (bram_we_a !== (e_w0 | e_w1)) begin errors++; $display("FAIL bram_we_a t=%0t got=%b exp=%b", $time, bram_we_a, e_w0 | e_w1); end
    checks++; if (bram_addr_a !== e_aa) begin errors++; $display("FAIL bram_addr_a t=%0t got=%h exp=%h", $time, bram_addr_a, e_aa); end
    checks++; if (bram_din_a !== e_din) begin errors++; $display("FAIL bram_din_a t=%0t got=%h exp=%h", $time, bram_din_a, e_din); end
    checks++; if (bram_en_b !== (e_r0 | e_r1)) begin errors++; $display("FAIL bram_en_b t=%0t got=%b exp=%b", $time, bram_en_b, e_r0 | e_r1); end
    checks++; if (bram_addr_b !== e_ab) begin errors++; $display("FAIL bram_addr_b t=%0t got=%h exp=%h", $time, bram_addr_b, e_ab); end
    checks++; if (m0_rvalid !== e_v0 || m1_rvalid !== e_v1) begin errors++; $display("FAIL rvalid t=%0t got=%b%b exp=%b%b", $time, m0_rvalid, m1_rvalid, e_v0, e_v1); end
    if (e_v0 | e_v1) begin
      checks++; if (m_rdata !== e_data) begin errors++; $display("FAIL m_rdata t=%0t got=%h exp=%h", $time, m_rdata, e_data); end
    end
    // Model advance: read sees pre-write contents, then apply this cycle's write.
    if (e_r0) sb.push_back('{master: 1'b0, data: shadow[m0_addr]});
    if (e_r1) sb.push_back('{master: 1'b1, data: shadow[m1_addr]});
    if (e_w0) shadow[m0_addr] = m0_wdata;
    if (e_w1) shadow[m1_addr] = m1_wdata;
    if (rst) begin
      mdl_wr_ptr = 1'b0; mdl_rd_ptr = 1'b0;
    end else begin
      if (e_w0 | e_w1) mdl_wr_ptr = e_w0;
      if (e_r0 | e_r1) mdl_rd_ptr = e_r0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    m0_valid = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic drive0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_valid = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drive1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_valid = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic apply_reset();
    idle(); rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive0(1'b1, 10'd1, 16'h1111); drive1(1'b1, 10'd2, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0 || obs_v0 !== 1'b0 || obs_v1 !== 1'b0) begin
        errors++; $display("FAIL reset_quiet got ready=%b%b rvalid=%b%b exp all 0", obs_r0, obs_r1, obs_v0, obs_v1);
      end
    end
    rst = 1'b0;
    step();
    checks++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin
      errors++; $display("FAIL reset_first_winner got ready=%b%b exp=10", obs_r0, obs_r1);
    end
    idle(); step();
  endtask

  task automatic test_write_read();
    apply_reset();
    drive0(1'b1, 10'd5, 16'h1234); step();
    drive0(1'b0, 10'd5, 16'h0000); step();
    checks++; if (obs_r0 !== 1'b1) begin errors++; $display("FAIL wr_rd_read_ready got=%b exp=1", obs_r0); end
    idle(); step();
    checks++; if (obs_v0 !== 1'b1 || obs_v1 !== 1'b0 || obs_data !== 16'h1234) begin
      errors++; $display("FAIL wr_rd_resp got v=%b%b data=%h exp v=10 data=1234", obs_v0, obs_v1, obs_data);
    end
  endtask

  task automatic test_write_contention();
    int cnt0, cnt1, wait0, wait1, max_wait;
    cnt0 = 0; cnt1 = 0; wait0 = 0; wait1 = 0; max_wait = 0;
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      drive0(1'b1, 10'd1, DW'(16'hA000 + n)); drive1(1'b1, 10'd2, DW'(16'hB000 + n));
      step();
      checks++; if (obs_r0 !== ((n % 2) == 0) || obs_r1 !== ((n % 2) == 1)) begin
        errors++; $display("FAIL wr_alternate n=%0d got ready=%b%b exp m%0d", n, obs_r0, obs_r1, n % 2);
      end
      if (obs_r0) begin cnt0++; wait0 = 0; end else wait0++;
      if (obs_r1) begin cnt1++; wait1 = 0; end else wait1++;
      if (wait0 > max_wait) max_wait = wait0;
      if (wait1 > max_wait) max_wait = wait1;
    end
    checks++; if (cnt0 != 3 || cnt1 != 3) begin errors++; $display("FAIL wr_counts got %0d/%0d exp 3/3", cnt0, cnt1); end
    checks++; if (max_wait > 1) begin errors++; $display("FAIL wr_starvation got wait=%0d exp<=1", max_wait); end
    idle();
    drive0(1'b0, 10'd1, '0); step();
    drive0(1'b0, 10'd2, '0); step();
    checks++; if (obs_data !== 16'hA004) begin errors++; $display("FAIL wr_last_m0 got=%h exp=a004", obs_data); end
    idle(); step();
    checks++; if (obs_data !== 16'hB005) begin errors++; $display("FAIL wr_last_m1 got=%h exp=b005", obs_data); end
  endtask

  task automatic test_read_contention();
    int c0, c1;
    c0 = 0; c1 = 0;
    apply_reset();
    drive0(1'b1, 10'd3, 16'h0033); step();
    drive0(1'b1, 10'd4, 16'h0044); step();
    drive0(1'b0, 10'd3, '0); drive1(1'b0, 10'd4, '0);
    for (int n = 0; n < 7; n++) begin
      if (n == 6) idle();
      step();
      checks++; if (obs_v0 === 1'b1 && obs_v1 === 1'b1) begin errors++; $display("FAIL rd_both_rvalid n=%0d got=11 exp one-hot", n); end
      if (obs_v0 === 1'b1) begin
        c0++;
        checks++; if (obs_data !== 16'h0033) begin errors++; $display("FAIL rd_route_m0 got=%h exp=0033", obs_data); end
      end
      if (obs_v1 === 1'b1) begin
        c1++;
        checks++; if (obs_data !== 16'h0044) begin errors++; $display("FAIL rd_route_m1 got=%h exp=0044", obs_data); end
      end
    end
    checks++; if (c0 != 3 || c1 != 3) begin errors++; $display("FAIL rd_counts got %0d/%0d exp 3/3", c0, c1); end
  endtask

  task automatic test_collision();
    apply_reset();
    drive0(1'b1, 10'd7, 16'h0007); step();
    idle();
    drive0(1'b0, 10'd7, '0); drive1(1'b1, 10'd7, 16'h7777); step();
    checks++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b1) begin errors++; $display("FAIL coll_ready got=%b%b exp=11", obs_r0, obs_r1); end
    idle();
    drive0(1'b0, 10'd7, '0); step();
    checks++; if (obs_data !== 16'h0007) begin errors++; $display("FAIL coll_old got=%h exp=0007", obs_data); end
    idle(); step();
    checks++; if (obs_data !== 16'h7777) begin errors++; $display("FAIL coll_new got=%h exp=7777", obs_data); end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    drive0(1'b0, 10'd0, '0); step();
    idle();
    drive1(1'b0, 10'd7, '0); step();
    checks++; if (obs_r1 !== 1'b1) begin errors++; $display("FAIL rmr_grant got=%b exp=1", obs_r1); end
    idle(); rst = 1'b1; step();
    checks++; if (obs_v1 !== 1'b0) begin errors++; $display("FAIL rmr_rvalid got=%b exp=0", obs_v1); end
    rst = 1'b0; step();
    checks++; if (obs_v1 !== 1'b0) begin errors++; $display("FAIL rmr_rvalid_after got=%b exp=0", obs_v1); end
    drive0(1'b0, 10'd7, '0); drive1(1'b0, 10'd7, '0); step();
    checks++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin errors++; $display("FAIL rmr_rd_ptr got=%b%b exp=10", obs_r0, obs_r1); end
    drive0(1'b1, 10'd8, 16'h0808); drive1(1'b1, 10'd9, 16'h0909); step();
    checks++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin errors++; $display("FAIL rmr_wr_ptr got=%b%b exp=10", obs_r0, obs_r1); end
    idle(); step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_write_contention();
    test_read_contention();
    test_collision();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter and sequencer in front of the inferred simple-dual-port block RAM: a write port A and a registered read port B with one-cycle read latency. It lets the processor pipeline (M0) and the HLS accelerator (M1) share one data memory. Write and read ports are arbitrated independently with round-robin fairness, and each read response is routed back to the requester that issued it. It sits between the two masters and the BRAM instance, and drives every BRAM control input.

## Interface

**Parameters**
- DATA_WIDTH, 16: word width; must match the BRAM.
- ADDR_WIDTH, 10: address width; must match the BRAM.

**Ports**
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- m0_valid, m1_valid, in, 1 each: request valid.
- m0_we, m1_we, in, 1 each: 1 = write, 0 = read.
- m0_addr, m1_addr, in, ADDR_WIDTH each: request address.
- m0_wdata, m1_wdata, in, DATA_WIDTH each: write data.
- m0_ready, m1_ready, out, 1 each: request accepted this cycle (valid & ready).
- m0_rvalid, m1_rvalid, out, 1 each: read data valid for that master.
- m_rdata, out, DATA_WIDTH: read data, shared by both masters; qualified by mX_rvalid.
- bram_we_a, out, 1: drives BRAM we_a.
- bram_addr_a, out, ADDR_WIDTH: drives BRAM addr_a.
- bram_din_a, out, DATA_WIDTH: drives BRAM din_a.
- bram_en_b, out, 1: drives BRAM en_b.
- bram_addr_b, out, ADDR_WIDTH: drives BRAM addr_b.
- bram_dout_b, in, DATA_WIDTH: from BRAM dout_b.

## Operation

**Request classes**
- A request with valid=1, we=1 competes for port A.
- A request with valid=1, we=0 competes for port B.
- Each master presents at most one request per cycle.

**Port grants**
- Port A grant is combinational from the valid/we inputs and the write pointer wr_ptr.
  - Only one master writing: it wins.
  - Both writing: the master equal to wr_ptr wins.
- Port B grant uses the same rule with the read pointer rd_ptr.
- One write and one read in the same cycle: both are granted, with no stall.

**Pointer update**
- On a port grant to master k, that port's pointer becomes 1-k on the next edge.
- A pointer is unchanged when its port has no grant.
- Reset value of both pointers is 0 (M0 preferred).

**Outputs**
- mX_ready = 1 exactly when master X wins its requested port. It is 0 when mX_valid=0.
- BRAM port A: bram_we_a=1 with the winner's addr/wdata.
  - With no winner, bram_we_a=0, and addr_a and din_a are driven 0.
- BRAM port B: bram_en_b=1 with the winner's addr.
  - With no winner, bram_en_b=0 and bram_addr_b=0, so the BRAM output register holds its value.

**Response tracking**
- A registered response tracker captures (rd_grant, rd_owner) each cycle.
- mX_rvalid = tracker valid & owner==X.
- m_rdata = bram_dout_b, passed through combinationally.

**Same-cycle collision**
- A write and a read to the same address in the same cycle return the OLD contents.
- Masters needing the new value must issue the read one cycle later.

**Reset**
- rst=1 clears wr_ptr, rd_ptr and the response tracker.
- All ready, rvalid, we and en outputs are 0 while rst=1.
- A read granted in the cycle before reset asserts produces no rvalid.

## Timing

- Request-to-grant latency: 0 cycles (combinational ready).
- Write commit: memory is updated at the edge ending the grant cycle.
- Read latency: grant in cycle N gives mX_rvalid=1 and valid m_rdata in cycle N+1 only.
- Throughput: one write plus one read per clock, sustained.
- Starvation bound: a continuously valid requester waits at most 1 cycle for its port.
- Response ordering: there are no back-pressure inputs on responses, so masters must accept rvalid when it occurs.
- Critical path: valid → grant → BRAM address pins. No registers are inserted on the request path.

## Test plan

- **Reset:** hold rst for 3 cycles with both masters requesting → all ready, rvalid, bram_we_a and bram_en_b are 0. After release, M0 wins the first write contention.
- **Write/read by one master:** M0 writes 0x1234 to addr 5, then reads addr 5 → m0_ready=1 in both cycles. m0_rvalid=1 with m_rdata=0x1234 one cycle after the read grant. m1_rvalid stays 0.
- **Write contention:** both masters write every cycle, M0 data 0xA000+n to addr 1, M1 data 0xB000+n to addr 2, for 6 cycles → grants alternate M0, M1, M0, …. Each master gets exactly 3 writes, and no master waits more than 1 cycle.
- **Read contention with routing:** memory preloaded with addr 3 = 0x0033 and addr 4 = 0x0044. M0 reads addr 3 and M1 reads addr 4, continuously → alternating rvalid pulses, each carrying its own master's data. The two rvalids are never high together.
- **Collision:** addr 7 = 0x0007. In one cycle M1 writes 0x7777 to addr 7 while M0 reads addr 7 → both ready=1. The next-cycle read data is 0x0007. A repeated read returns 0x7777.
- **Reset mid-read:** M1 is granted a read in cycle N and rst is asserted in cycle N+1 → m1_rvalid stays 0. Pointers return to 0.
